// File: rtl/daq_sample_sequencer_if.sv
// Sample stream from the acquisition sequencer to the downstream buffer.
// The sequencer drives the master side; the buffer drives the slave side.
interface daq_sample_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 2
) ();
    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;

    modport master (
        output sample_valid,
        output sample_data,
        output sample_ch,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        input  sample_ch,
        output sample_ready
    );
endinterface

// File: rtl/daq_sample_sequencer.sv
// Turns each rising edge of the divided tick into one ADC conversion, scanning
// channels round-robin and presenting every result over a valid/ready stream.
module daq_sample_sequencer #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_clk,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              timeout_err,
    output logic [7:0]        overrun_cnt,
    daq_sample_sequencer_if.master sample_if
);

    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]    LAST_CH     = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                new_clk_q;
    logic [CH_W-1:0]     channel_q, channel_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                adc_start_q, adc_start_d;
    logic                timeout_err_q, timeout_err_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
    logic [7:0]          overrun_q, overrun_d;

    logic                tick;
    logic [CH_W-1:0]     channel_next;

    assign tick         = new_clk & ~new_clk_q;
    assign channel_next = (channel_q == LAST_CH) ? '0 : channel_q + CH_W'(1);

    always_comb begin
        state_d       = state_q;
        channel_d     = channel_q;
        timer_d       = timer_q;
        adc_start_d   = 1'b0;
        timeout_err_d = 1'b0;
        valid_d       = valid_q;
        data_d        = data_q;
        sample_ch_d   = sample_ch_q;
        overrun_d     = overrun_q;

        // Ticks are never queued: anything arriving outside IDLE is dropped.
        if (tick && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d     = S_START;
                    adc_start_d = 1'b1;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final allowed cycle still beats the timeout.
                if (adc_done) begin
                    data_d      = adc_data;
                    sample_ch_d = channel_q;
                    valid_d     = 1'b1;
                    state_d     = S_HOLD;
                end else if (timer_q == TIMER_LIMIT) begin
                    timeout_err_d = 1'b1;
                    channel_d     = channel_next;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_HOLD: begin
                if (valid_q && sample_if.sample_ready) begin
                    valid_d   = 1'b0;
                    channel_d = channel_next;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Tracking new_clk during reset keeps a level held high from looking like an edge.
            new_clk_q     <= new_clk;
            state_q       <= S_IDLE;
            channel_q     <= '0;
            timer_q       <= '0;
            adc_start_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            sample_ch_q   <= '0;
            overrun_q     <= 8'd0;
        end else begin
            new_clk_q     <= new_clk;
            state_q       <= state_d;
            channel_q     <= channel_d;
            timer_q       <= timer_d;
            adc_start_q   <= adc_start_d;
            timeout_err_q <= timeout_err_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            sample_ch_q   <= sample_ch_d;
            overrun_q     <= overrun_d;
        end
    end

    assign adc_start              = adc_start_q;
    assign adc_ch                 = channel_q;
    assign timeout_err            = timeout_err_q;
    assign overrun_cnt            = overrun_q;
    assign sample_if.sample_valid = valid_q;
    assign sample_if.sample_data  = data_q;
    assign sample_if.sample_ch    = sample_ch_q;

endmodule

// File: tb/tb_daq_sample_sequencer.sv
// Directed bench for the acquisition sequencer: reset, round-robin scan,
// timeout boundary, back-pressure with overruns, and reset mid-conversion.
module tb_daq_sample_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_clk;
    logic       adc_start;
    logic [1:0] adc_ch;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       timeout_err;
    logic [7:0] overrun_cnt;

    int checks_cnt = 0;
    int errors_cnt = 0;

    daq_sample_sequencer_if #(.DATA_W(8), .CH_W(2)) sif ();

    daq_sample_sequencer #(
        .DATA_W (8),
        .NUM_CH (4),
        .CH_W   (2),
        .TIMEOUT(255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .new_clk    (new_clk),
        .adc_start  (adc_start),
        .adc_ch     (adc_ch),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .timeout_err(timeout_err),
        .overrun_cnt(overrun_cnt),
        .sample_if  (sif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Inputs set after step() are seen at the next rising edge; outputs read
    // after step() are the registered values for the current cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One full conversion with immediate ready: tick, start, done, sample, handshake.
    task automatic do_conv(input logic [1:0] ch, input logic [7:0] d, input string tag);
        new_clk = 1'b1;
        step();
        check_eq({tag, " start"}, 32'(adc_start), 32'd1);
        check_eq({tag, " adc_ch"}, 32'(adc_ch), 32'(ch));
        new_clk = 1'b0;
        step();
        check_eq({tag, " start one cycle"}, 32'(adc_start), 32'd0);
        adc_done = 1'b1;
        adc_data = d;
        step();
        adc_done = 1'b0;
        check_eq({tag, " valid"}, 32'(sif.sample_valid), 32'd1);
        check_eq({tag, " data"}, 32'(sif.sample_data), 32'(d));
        check_eq({tag, " sample_ch"}, 32'(sif.sample_ch), 32'(ch));
        sif.sample_ready = 1'b1;
        step();
        sif.sample_ready = 1'b0;
        check_eq({tag, " valid drop"}, 32'(sif.sample_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int starts;
        int pulses;
        int pulse_at;
        int valid_seen;
        int changes;

        rst              = 1'b1;
        new_clk          = 1'b1;
        adc_done         = 1'b0;
        adc_data         = 8'h00;
        sif.sample_ready = 1'b0;
        repeat (3) step();

        // 1: reset values, and new_clk held high across release must not tick
        check_eq("rst adc_start", 32'(adc_start), 32'd0);
        check_eq("rst adc_ch", 32'(adc_ch), 32'd0);
        check_eq("rst valid", 32'(sif.sample_valid), 32'd0);
        check_eq("rst data", 32'(sif.sample_data), 32'd0);
        check_eq("rst sample_ch", 32'(sif.sample_ch), 32'd0);
        check_eq("rst timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rst overrun", 32'(overrun_cnt), 32'd0);
        rst    = 1'b0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (adc_start) starts++;
        end
        check_eq("held new_clk starts", 32'(starts), 32'd0);
        check_eq("held new_clk overrun", 32'(overrun_cnt), 32'd0);
        new_clk = 1'b0;
        step();

        // 2: single conversion, then channel advances to 1
        do_conv(2'd0, 8'hA5, "t2");
        check_eq("t2 next adc_ch", 32'(adc_ch), 32'd1);

        // 3: five conversions from reset wrap 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_conv(2'(i % 4), 8'(8'h10 + i), $sformatf("t3 conv%0d", i));
        end
        check_eq("t3 adc_ch after wrap", 32'(adc_ch), 32'd1);

        // 4: timeout; limit seen in the 255th WAIT cycle, registered pulse the cycle after
        do_reset();
        new_clk = 1'b1;
        step();
        check_eq("t4 start", 32'(adc_start), 32'd1);
        new_clk    = 1'b0;
        pulses     = 0;
        pulse_at   = -1;
        valid_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (timeout_err) begin
                pulses++;
                if (pulses == 1) pulse_at = i;
            end
            if (sif.sample_valid) valid_seen++;
        end
        check_eq("t4 timeout pulses", 32'(pulses), 32'd1);
        check_eq("t4 timeout cycle after start", 32'(pulse_at), 32'd256);
        check_eq("t4 no sample", 32'(valid_seen), 32'd0);
        check_eq("t4 next adc_ch", 32'(adc_ch), 32'd1);

        // 4b: done on the final allowed WAIT cycle wins over the timeout
        new_clk = 1'b1;
        step();
        new_clk = 1'b0;
        pulses  = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (timeout_err) pulses++;
        end
        adc_done = 1'b1;
        adc_data = 8'h3C;
        step();
        adc_done = 1'b0;
        if (timeout_err) pulses++;
        check_eq("t4b valid", 32'(sif.sample_valid), 32'd1);
        check_eq("t4b data", 32'(sif.sample_data), 32'h3C);
        check_eq("t4b sample_ch", 32'(sif.sample_ch), 32'd1);
        check_eq("t4b no timeout", 32'(pulses), 32'd0);
        sif.sample_ready = 1'b1;
        step();
        sif.sample_ready = 1'b0;

        // 5: back-pressure for 300 cycles with three dropped ticks
        new_clk = 1'b1;
        step();
        new_clk = 1'b0;
        step();
        adc_done = 1'b1;
        adc_data = 8'h5A;
        step();
        adc_done = 1'b0;
        check_eq("t5 valid", 32'(sif.sample_valid), 32'd1);
        changes = 0;
        for (int i = 0; i < 300; i++) begin
            new_clk = (i == 50 || i == 150 || i == 250);
            step();
            if (sif.sample_data != 8'h5A || sif.sample_ch != 2'd2 || !sif.sample_valid) changes++;
        end
        new_clk = 1'b0;
        check_eq("t5 sample stable", 32'(changes), 32'd0);
        check_eq("t5 overrun", 32'(overrun_cnt), 32'd3);
        sif.sample_ready = 1'b1;
        check_eq("t5 valid with ready", 32'(sif.sample_valid), 32'd1);
        step();
        sif.sample_ready = 1'b0;
        check_eq("t5 valid dropped", 32'(sif.sample_valid), 32'd0);

        // 6: reset during WAIT, late done ignored, then saturate overrun
        step();
        new_clk = 1'b1;
        step();
        new_clk = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        adc_done = 1'b1;
        adc_data = 8'hFF;
        step();
        adc_done = 1'b0;
        check_eq("t6 valid after rst", 32'(sif.sample_valid), 32'd0);
        check_eq("t6 adc_ch after rst", 32'(adc_ch), 32'd0);
        check_eq("t6 overrun after rst", 32'(overrun_cnt), 32'd0);
        step();
        check_eq("t6 no start", 32'(adc_start), 32'd0);
        do_conv(2'd0, 8'h11, "t6 idle");
        new_clk = 1'b1;
        step();
        new_clk = 1'b0;
        step();
        adc_done = 1'b1;
        adc_data = 8'h77;
        step();
        adc_done = 1'b0;
        for (int k = 0; k < 260; k++) begin
            new_clk = 1'b1;
            step();
            new_clk = 1'b0;
            step();
        end
        check_eq("t6 overrun saturated", 32'(overrun_cnt), 32'd255);
        check_eq("t6 held data", 32'(sif.sample_data), 32'h77);
        check_eq("t6 held sample_ch", 32'(sif.sample_ch), 32'd1);
        sif.sample_ready = 1'b1;
        step();
        sif.sample_ready = 1'b0;
        check_eq("t6 final valid drop", 32'(sif.sample_valid), 32'd0);
        check_eq("t6 final adc_ch", 32'(adc_ch), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
